// File: rtl/mux4_rr_sched_pkg.sv
// Shared types and helpers for the mux4_rr_sched round-robin scheduler.
// Optional feature macro: MUX4_RR_SCHED_LOCK_EN (adds the lock input).
package mux4_rr_sched_pkg;

    // Number of requesters sharing the mux; the 2-bit select and pointer assume 4.
    localparam int NREQ = 4;

    // IDLE: no word on the output. BUSY: a word is held until the sink takes it.
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Decode a 2-bit requester index into a 4-bit one-hot vector.
    function automatic logic [NREQ-1:0] onehot2(input logic [1:0] idx);
        onehot2 = 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/mux4_rr_sched_rr_pick4.sv
// rr_pick4: combinational round-robin picker over four requests.
// Searches ptr, ptr+1, ptr+2, ptr+3 (2-bit wrap) and returns the first set request.
// Used with MUX4_RR_SCHED_LOCK_EN both defined and undefined; it has no lock port.
module rr_pick4
    import mux4_rr_sched_pkg::*;
(
    input  logic [NREQ-1:0] req_i,
    input  logic [1:0]      ptr_i,
    output logic            found_o,
    output logic [1:0]      idx_o
);

    // Priority search: walk the offsets from lowest to highest priority so the
    // last hit written, i.e. the one closest to ptr, is the one that sticks.
    always_comb begin
        logic [1:0] cand;
        // NOTE: every output of a combinational block gets a default before any
        // conditional assignment, otherwise the tool infers a latch to hold it.
        found_o = 1'b0;
        idx_o   = ptr_i;
        cand    = ptr_i;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = ptr_i + 2'(k);
            if (req_i[cand]) begin
                found_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/mux4_rr_sched.sv
// mux4_rr_sched: round-robin scheduler sharing one 4:1 data mux between four
// requesters, with a registered valid/ready output stage.
// Optional feature macro: MUX4_RR_SCHED_LOCK_EN adds a 'lock' input; an accept
// with lock=1 keeps the pointer on the served requester and does not mask it,
// so a still-requesting winner is served again on the next transfer (burst).
module mux4_rr_sched
    import mux4_rr_sched_pkg::*;
#(
    parameter int DW = 3
) (
    input  logic            clk,
    input  logic            rst_n,
`ifdef MUX4_RR_SCHED_LOCK_EN
    input  logic            lock,
`endif
    input  logic [NREQ-1:0] req,
    input  logic [DW-1:0]   i0,
    input  logic [DW-1:0]   i1,
    input  logic [DW-1:0]   i2,
    input  logic [DW-1:0]   i3,
    output logic [NREQ-1:0] gnt,
    output logic            s1,
    output logic            s0,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW-1:0]   out_data
);

    state_t          state_q, state_d;
    logic [1:0]      ptr_q, ptr_d;
    logic [1:0]      sel_q, sel_d;
    logic [DW-1:0]   data_q, data_d;
    logic            valid_q, valid_d;

    logic            accept;
    logic            lock_acc;
    logic [NREQ-1:0] pick_req;
    logic [1:0]      pick_ptr;
    logic            pick_found;
    logic [1:0]      pick_idx;
    logic [DW-1:0]   pick_data;

    // A transfer completes whenever the held word meets a ready sink.
    assign accept = valid_q & out_ready;

`ifdef MUX4_RR_SCHED_LOCK_EN
    assign lock_acc = accept & lock;
`else
    assign lock_acc = 1'b0;
`endif

    // Choose what the single picker arbitrates over: fresh requests from ptr in
    // IDLE, or the remaining requests from just past the winner on an accept.
    always_comb begin
        pick_req = req;
        pick_ptr = ptr_q;
        if (state_q == BUSY) begin
            if (lock_acc) begin
                pick_req = req;
                pick_ptr = sel_q;
            end else begin
                pick_req = req & ~onehot2(sel_q);
                pick_ptr = sel_q + 2'd1;
            end
        end
    end

    rr_pick4 u_pick (
        .req_i   (pick_req),
        .ptr_i   (pick_ptr),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    // The shared 4:1 data mux, steered by the candidate winner.
    always_comb begin
        pick_data = i0;
        case (pick_idx)
            2'd0:    pick_data = i0;
            2'd1:    pick_data = i1;
            2'd2:    pick_data = i2;
            default: pick_data = i3;
        endcase
    end

    // Next-state and output-register logic for the IDLE/BUSY scheduler.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        data_d  = data_q;
        valid_d = valid_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    sel_d   = pick_idx;
                    data_d  = pick_data;
                    valid_d = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                // Without an accept everything holds: no re-arbitration under backpressure.
                if (accept) begin
                    ptr_d = lock_acc ? sel_q : sel_q + 2'd1;
                    if (pick_found) begin
                        sel_d  = pick_idx;
                        data_d = pick_data;
                    end else begin
                        valid_d = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset clears the in-flight word immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= 2'd0;
            sel_q   <= 2'd0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    // Acceptance strobe is combinational so the requester sees it in the accept cycle.
    assign gnt       = accept ? onehot2(sel_q) : '0;
    assign s1        = sel_q[1];
    assign s0        = sel_q[0];
    assign out_valid = valid_q;
    assign out_data  = data_q;

endmodule

// File: tb/tb_mux4_rr_sched.sv
// Scoreboard bench for mux4_rr_sched: directed stimulus pushes expected words,
// a monitor pops and compares on every accepted transfer.
// Lock scenario is compiled only with MUX4_RR_SCHED_LOCK_EN.
module tb_mux4_rr_sched;

    localparam int DW = 3;

    typedef struct packed {
        logic [1:0]    idx;
        logic [DW-1:0] data;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [3:0]    req;
    logic [DW-1:0] din [4];
    logic [3:0]    gnt;
    logic          s1, s0;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
`ifdef MUX4_RR_SCHED_LOCK_EN
    logic          lock;
`endif

    exp_t          sb [$];
    logic [DW-1:0] rq [4][$];
    int            n_vec  = 0;
    int            n_miss = 0;

    mux4_rr_sched #(.DW(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef MUX4_RR_SCHED_LOCK_EN
        .lock      (lock),
`endif
        .req       (req),
        .i0        (din[0]),
        .i1        (din[1]),
        .i2        (din[2]),
        .i3        (din[3]),
        .gnt       (gnt),
        .s1        (s1),
        .s0        (s0),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] oh(input logic [1:0] idx);
        oh = 4'b0001 << idx;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic load(input int i, input logic [DW-1:0] v);
        rq[i].push_back(v);
    endtask

    task automatic expect_word(input logic [1:0] idx, input logic [DW-1:0] v);
        sb.push_back({idx, v});
    endtask

    // Wait until every expected word has been consumed and the output is idle.
    task automatic drain(input int max_cycles, output int cycles);
        bit done;
        done   = 1'b0;
        cycles = 0;
        while (!done && cycles < max_cycles) begin
            @(negedge clk);
            cycles++;
            if (sb.size() == 0 && !out_valid) done = 1'b1;
        end
        if (!done) check("drain_timeout", 8'(sb.size()), 8'd0);
    endtask

    // Requester model: holds req until its gnt is seen, then moves to its next word.
    initial begin : driver
        logic [3:0] g;
        req = 4'b0;
        for (int i = 0; i < 4; i++) din[i] = '0;
        forever begin
            @(negedge clk);
            #2;
            g = gnt;
            @(posedge clk);
            #1;
            for (int i = 0; i < 4; i++) begin
                if (g[i] && rq[i].size() > 0) void'(rq[i].pop_front());
                req[i] = (rq[i].size() > 0);
                din[i] = (rq[i].size() > 0) ? rq[i][0] : '0;
            end
        end
    end

    // Monitor: compares every accepted word against the scoreboard, and checks
    // that no strobe appears without a transfer.
    initial begin : monitor
        exp_t       e;
        logic [3:0] prev_req = 4'b0;
        logic [3:0] prev_gnt = 4'b0;
        logic       prev_rst = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n) begin
                if (prev_rst)
                    assert ((prev_req & ~req & ~prev_gnt) == 4'b0)
                        else $error("requester dropped req before gnt");
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        check("sb_unexpected_word", 8'(out_data), 8'hff);
                    end else begin
                        e = sb.pop_front();
                        check("xfer_data", 8'(out_data), 8'(e.data));
                        check("xfer_sel", 8'({s1, s0}), 8'(e.idx));
                        check("xfer_gnt", 8'(gnt), 8'(oh(e.idx)));
                    end
                end else begin
                    check("gnt_no_xfer", 8'(gnt), 8'd0);
                end
            end
            prev_req = req;
            prev_gnt = gnt;
            prev_rst = rst_n;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int cyc;
        rst_n     = 1'b0;
        out_ready = 1'b0;
`ifdef MUX4_RR_SCHED_LOCK_EN
        lock      = 1'b0;
`endif
        // Reset values.
        repeat (2) @(negedge clk);
        check("rst_valid", 8'(out_valid), 8'd0);
        check("rst_data", 8'(out_data), 8'd0);
        check("rst_sel", 8'({s1, s0}), 8'd0);
        check("rst_gnt", 8'(gnt), 8'd0);
        rst_n = 1'b1;

        // Async reset while a word is held under backpressure: word dropped.
        load(1, 3'd6);
        repeat (2) @(negedge clk);
        check("pre_rst_valid", 8'(out_valid), 8'd1);
        check("pre_rst_data", 8'(out_data), 8'd6);
        check("pre_rst_sel", 8'({s1, s0}), 8'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 8'(out_valid), 8'd0);
        check("midrst_sel", 8'({s1, s0}), 8'd0);
        check("midrst_gnt", 8'(gnt), 8'd0);
        check("midrst_data", 8'(out_data), 8'd0);
        for (int i = 0; i < 4; i++) rq[i].delete();
        sb.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Fairness: all four requesting, two words each, ptr starts at 0.
        // Eight back-to-back transfers plus one fill and one empty cycle = 10.
        out_ready = 1'b1;
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < 4; i++) begin
                load(i, 3'(i));
                expect_word(2'(i), 3'(i));
            end
        drain(40, cyc);
        check("fair_cycles", 8'(cyc), 8'd10);

        // Single request from 2 with a ready sink: valid one cycle after req.
        load(2, 3'd5);
        expect_word(2'd2, 3'd5);
        @(negedge clk);
        check("single_lat_n", 8'(out_valid), 8'd0);
        @(negedge clk);
        check("single_lat_n1", 8'(out_valid), 8'd1);
        check("single_data", 8'(out_data), 8'd5);
        check("single_sel", 8'({s1, s0}), 8'd2);
        check("single_gnt", 8'(gnt), 8'b0100);
        @(negedge clk);
        check("single_idle_valid", 8'(out_valid), 8'd0);
        check("single_idle_gnt", 8'(gnt), 8'd0);
        drain(20, cyc);

        // Wrap: ptr is 3 after serving 2; requests 3 and 0 -> 3 then 0.
        load(0, 3'd4);
        load(3, 3'd3);
        expect_word(2'd3, 3'd3);
        expect_word(2'd0, 3'd4);
        drain(20, cyc);

        // Backpressure: ptr is 1; word from 1 held for five cycles, then accepted.
        out_ready = 1'b0;
        load(1, 3'd7);
        expect_word(2'd1, 3'd7);
        repeat (2) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            check("bp_valid", 8'(out_valid), 8'd1);
            check("bp_data", 8'(out_data), 8'd7);
            check("bp_sel", 8'({s1, s0}), 8'd1);
            check("bp_gnt", 8'(gnt), 8'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_gnt", 8'(gnt), 8'b0010);
        drain(20, cyc);

`ifdef MUX4_RR_SCHED_LOCK_EN
        // Lock: ptr is 2; requests 0 and 1; lock on first accept of 0 -> 0,0,1.
        lock = 1'b1;
        load(0, 3'd5);
        load(0, 3'd5);
        load(1, 3'd6);
        expect_word(2'd0, 3'd5);
        expect_word(2'd0, 3'd5);
        expect_word(2'd1, 3'd6);
        repeat (2) @(negedge clk);
        check("lock_first_sel", 8'({s1, s0}), 8'd0);
        @(negedge clk);
        lock = 1'b0;
        check("lock_again_sel", 8'({s1, s0}), 8'd0);
        drain(20, cyc);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
